// File: rtl/aurora_hls_nfc_controller.sv
// aurora_hls_nfc_controller
// Native-flow-control sequencer: watches the RX FIFO fill level against the
// stop/start thresholds and sends XOFF/XON messages to the Aurora core's NFC
// AXI-Stream input over a valid/ready handshake. It also exports the pause
// state and accepted-message counters.
// Optional feature macro: NFC_REFRESH_EN re-issues XOFF every REFRESH_INTERVAL
// cycles while paused, so the core's pause count never expires.
module aurora_hls_nfc_controller #(
    parameter int          FILL_WIDTH       = 16,
    parameter logic [15:0] XOFF_DATA        = 16'hFF00,
    parameter logic [15:0] XON_DATA         = 16'h0000,
    parameter int          REFRESH_INTERVAL = 1024
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  channel_up,
    input  logic [31:0]           fifo_thresholds,
    input  logic [FILL_WIDTH-1:0] rx_fifo_fill,
    output logic                  nfc_tvalid,
    input  logic                  nfc_tready,
    output logic [15:0]           nfc_tdata,
    output logic                  paused,
    output logic [31:0]           xoff_count,
    output logic [31:0]           xon_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SEND_XOFF = 2'd1,
        PAUSED    = 2'd2,
        SEND_XON  = 2'd3
    } nfc_state_t;

    nfc_state_t state;

    logic [FILL_WIDTH-1:0] stop_level;
    logic [FILL_WIDTH-1:0] start_level;
    logic                  xoff_needed;
    logic                  xon_needed;

    // Threshold fields are compared against the fill level as unsigned values;
    // a zero stop threshold disables flow control entirely.
    assign stop_level  = FILL_WIDTH'(fifo_thresholds[15:0]);
    assign start_level = FILL_WIDTH'(fifo_thresholds[31:16]);
    assign xoff_needed = (stop_level != '0) && (rx_fifo_fill >= stop_level);
    assign xon_needed  = (rx_fifo_fill <= start_level);

`ifdef NFC_REFRESH_EN
    localparam int TIMER_WIDTH = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(REFRESH_INTERVAL - 1);
    logic [TIMER_WIDTH-1:0] refresh_timer;
`endif

    // Sequencer with registered handshake, pause flag and counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= RUN;
            nfc_tvalid <= 1'b0;
            nfc_tdata  <= 16'h0000;
            paused     <= 1'b0;
            xoff_count <= 32'd0;
            xon_count  <= 32'd0;
`ifdef NFC_REFRESH_EN
            refresh_timer <= '0;
`endif
        end else if (!channel_up) begin
            // Link down: the core ignores NFC, so drop everything but the counters.
            state      <= RUN;
            nfc_tvalid <= 1'b0;
            paused     <= 1'b0;
`ifdef NFC_REFRESH_EN
            refresh_timer <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (xoff_needed) begin
                        state      <= SEND_XOFF;
                        nfc_tvalid <= 1'b1;
                        nfc_tdata  <= XOFF_DATA;
                    end
                end
                SEND_XOFF: begin
                    if (nfc_tready) begin
                        state      <= PAUSED;
                        nfc_tvalid <= 1'b0;
                        paused     <= 1'b1;
                        xoff_count <= xoff_count + 32'd1;
`ifdef NFC_REFRESH_EN
                        refresh_timer <= '0;
`endif
                    end
                end
                PAUSED: begin
                    if (xon_needed) begin
                        state      <= SEND_XON;
                        nfc_tvalid <= 1'b1;
                        nfc_tdata  <= XON_DATA;
                    end
`ifdef NFC_REFRESH_EN
                    else if (refresh_timer == TIMER_LAST) begin
                        state      <= SEND_XOFF;
                        nfc_tvalid <= 1'b1;
                        nfc_tdata  <= XOFF_DATA;
                    end else begin
                        refresh_timer <= refresh_timer + 1'b1;
                    end
`endif
                end
                SEND_XON: begin
                    if (nfc_tready) begin
                        state      <= RUN;
                        nfc_tvalid <= 1'b0;
                        paused     <= 1'b0;
                        xon_count  <= xon_count + 32'd1;
                    end
                end
                default: begin
                    state      <= RUN;
                    nfc_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aurora_hls_nfc_controller.md
# aurora_hls_nfc_controller

Native-flow-control (NFC) sequencer between the receive FIFO and the Aurora core's NFC AXI-Stream input. It watches the RX FIFO fill level against the static `fifo_thresholds` word produced by `aurora_hls_configuration`. It issues XOFF when the FIFO crosses the stop threshold and XON when it drains to the start threshold, completing each message with a valid/ready handshake. It also exports pause state and message counters for the host status registers.

## Interface
- `FILL_WIDTH`, 16: width of the fill level and of each threshold field.
- `XOFF_DATA`, 16'hFF00: NFC tdata driven for an XOFF (maximum pause count).
- `XON_DATA`, 16'h0000: NFC tdata driven for an XON (pause count 0).
- `REFRESH_INTERVAL`, 1024: cycles between XOFF re-issues while paused. Used only with `NFC_REFRESH_EN`; minimum 2.
- `ap_clk`  in  1  sole clock; everything is synchronous to its rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `channel_up`  in  1  Aurora link status; low forces the block to idle.
- `fifo_thresholds`  in  32  [15:0] stop threshold, [31:16] start threshold. Static.
- `rx_fifo_fill`  in  FILL_WIDTH  current RX FIFO occupancy in words.
- `nfc_tvalid`  out  1  NFC message valid.
- `nfc_tready`  in  1  core accepts the message.
- `nfc_tdata`  out  16  NFC message.
- `paused`  out  1  high from an accepted XOFF until an accepted XON.
- `xoff_count`  out  32  accepted XOFF messages; wraps modulo 2^32.
- `xon_count`  out  32  accepted XON messages; wraps modulo 2^32.

## Operation
- All outputs reset to 0. The state machine resets to RUN.
- Let stop = `fifo_thresholds[15:0]` and start = `fifo_thresholds[31:16]`. Compare each threshold with `rx_fifo_fill` as an unsigned value.
- stop == 0 disables NFC: the block never leaves RUN.
- Hysteresis is only guaranteed when start < stop. If start ≥ stop, the block still applies the rules below literally.
- State machine:
  - RUN: if `channel_up` and stop ≠ 0 and fill ≥ stop, go to SEND_XOFF.
  - SEND_XOFF: `nfc_tvalid`=1, `nfc_tdata`=XOFF_DATA. When `nfc_tready`=1, increment `xoff_count`, set `paused`, and go to PAUSED.
  - PAUSED: if fill ≤ start, go to SEND_XON.
  - SEND_XON: `nfc_tvalid`=1, `nfc_tdata`=XON_DATA. When `nfc_tready`=1, increment `xon_count`, clear `paused`, and go to RUN.
- A message in flight is never aborted or changed because the fill level moves.
  - tdata stays stable while tvalid=1 and tready=0.
  - After an XOFF completes, PAUSED evaluates fill on the next cycle. If fill ≤ start already, the XON follows immediately.
- `channel_up` low in any state, on the next edge:
  - state goes to RUN; `nfc_tvalid` and `paused` go to 0.
  - The refresh timer clears.
  - Counters are kept.
  - This is the only case where tvalid may drop without a handshake; the link is down, so the core ignores NFC.
- Counters increment only on a handshake cycle (tvalid & tready) and wrap silently.

## Timing
- Registered outputs. `nfc_tvalid` rises on the first edge after the sampled fill meets the condition: 1 cycle of latency from fill to tvalid.
- With tready held high, each message lasts exactly 1 cycle.
- `paused` and the counters update on the same edge that completes the handshake.
- The earliest XOFF→XON turnaround is: XOFF handshake edge, then 1 PAUSED cycle, then tvalid for the XON.
- Asserting `ap_rst_n` low mid-message drops tvalid immediately, without waiting for a clock edge.

## Configuration
- `NFC_REFRESH_EN` defined: a timer counts in PAUSED, starting at 0 on entry. When it reaches REFRESH_INTERVAL-1 with fill > start, the block returns to SEND_XOFF and re-issues XOFF. That XOFF counts in `xoff_count` and `paused` stays 1. This covers the expiry of the pause count in the core. The XON condition has priority over refresh in the same cycle.
- `NFC_REFRESH_EN` undefined: the timer is not built. PAUSED leaves only on the XON condition or on `channel_up` low.

## Test plan
- Thresholds 0x0040_00C0, `channel_up`=1, tready=1, fill ramps 0→0xC0: tvalid with tdata 0xFF00 for 1 cycle, one cycle after fill=0xC0; then `paused`=1 and `xoff_count`=1.
- Same setup, fill drops to 0x41 and then 0x40: no message at 0x41. At 0x40, tdata 0x0000 for 1 cycle; `paused`=0, `xon_count`=1.
- tready held low for 5 cycles during an XOFF while fill drops to 0: tdata stays 0xFF00 for all 5 cycles. The XON is issued 2 cycles after the handshake.
- stop field 0 with fill 0xFFFF: tvalid never rises and the counters stay 0.
- `channel_up` falls during SEND_XOFF with tready=0: tvalid=0 and `paused`=0 on the next edge; counters unchanged. Separately, an `ap_rst_n` pulse clears all outputs.
- With `NFC_REFRESH_EN` and REFRESH_INTERVAL=8, fill held at 0xFF: XOFF re-issued every 9 cycles (8 PAUSED cycles plus 1 SEND cycle) while tready=1, and `xoff_count` increments each time.
